multicycle_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the RV32 subset datapath. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB with req/ack handshakes to instruction and data memory.
- Gates the combinational control-unit strobes (register write, memory write, PC select) so architectural state changes only in the correct phase, exactly once per instruction.
- Counts retired instructions. Traps on illegal opcodes and on memory timeouts.

---
 rtl/multicycle_sequencer.sv | 140 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32 subset datapath.
// Gates control-unit strobes to the correct phase, counts retirements, traps on faults.
module multicycle_sequencer #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             ctl_reg_wen,
  input  logic             ctl_mem_w,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEM     = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_TRAP    = 3'd6;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Wait counter only needs to reach TIMEOUT-1: the cycle that hits it decides trap vs ack.
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [2:0]      state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            trap_nxt;
  logic [1:0]      trap_cause_nxt;
  logic            cnt_inc;
  logic            legal_op;
  logic            mem_op;
  logic            to_hit;

  assign legal_op = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                   7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
  assign mem_op   = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign to_hit   = (TIMEOUT > 0) && (to_cnt == TO_W'(TO_LAST));

  // State, wait counter, trap status and retirement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      instr_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      to_cnt     <= to_cnt_nxt;
      trap       <= trap_nxt;
      trap_cause <= trap_cause_nxt;
      if (cnt_inc) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Next-state and phase-gated strobe decode
  always_comb begin
    state_nxt      = state;
    to_cnt_nxt     = '0;
    trap_nxt       = trap;
    trap_cause_nxt = trap_cause;
    cnt_inc        = 1'b0;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    ir_we          = 1'b0;
    rf_we          = 1'b0;
    pc_we          = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (to_hit) begin
          state_nxt      = S_TRAP;
          trap_nxt       = 1'b1;
          trap_cause_nxt = CAUSE_IMEM_TO;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          state_nxt = S_EXECUTE;
        end else begin
          state_nxt      = S_TRAP;
          trap_nxt       = 1'b1;
          trap_cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: state_nxt = mem_op ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctl_mem_w;
        if (dmem_ack) begin
          state_nxt = S_WB;
        end else if (to_hit) begin
          state_nxt      = S_TRAP;
          trap_nxt       = 1'b1;
          trap_cause_nxt = CAUSE_DMEM_TO;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      S_WB: begin
        rf_we     = ctl_reg_wen;
        pc_we     = 1'b1;
        cnt_inc   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: per-instruction expected traces are built
// from the phase rules (fetch wait, decode, execute, optional mem wait, writeback).
module tb_multicycle_sequencer;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 15;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic             clk;
  logic             rst;
  logic [6:0]       opcode;
  logic             ctl_reg_wen;
  logic             ctl_mem_w;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_we;
  logic             rf_we;
  logic             pc_we;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  multicycle_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ctl_reg_wen(ctl_reg_wen),
    .ctl_mem_w(ctl_mem_w), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .rf_we(rf_we), .pc_we(pc_we), .trap(trap), .trap_cause(trap_cause),
    .state(state), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_cnt  = 0;
  logic [1:0] exp_cause = 2'b00;
  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};

  logic [11:0] obs;
  assign obs = {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, trap, trap_cause, state};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [11:0] exp_vec(input logic [2:0] st, input logic ireq, input logic dreq,
                                          input logic dwe, input logic irwe, input logic rfwe,
                                          input logic pcwe, input logic tr, input logic [1:0] cause);
    return {ireq, dreq, dwe, irwe, rfwe, pcwe, tr, cause, st};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check outputs mid-cycle, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic [11:0] ev);
    @(negedge clk);
    check_eq(tag, 32'(obs), 32'(ev));
    check_eq({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt % (1 << CNT_W)));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_side();
    ctl_reg_wen = 1'($urandom_range(0, 1));
    ctl_mem_w   = 1'($urandom_range(0, 1));
    imem_ack    = 1'($urandom_range(0, 1));
    dmem_ack    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_side();
    @(posedge clk);
    #1;
    exp_cnt   = 0;
    exp_cause = 2'b00;
    cyc("reset", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    rst = 1'b0;
    rand_side();
    cyc("idle", exp_vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
  endtask

  // idly/ddly: cycles the memory leaves ack low before answering
  task automatic do_instr(input logic [6:0] op, input int idly, input int ddly, output bit trapped);
    trapped = 1'b0;
    opcode  = op;
    for (int c = 0; c < int'(TIMEOUT); c++) begin
      rand_side();
      imem_ack = 1'(c == idly);
      cyc("fetch", exp_vec(3'd1, 1'b1, 1'b0, 1'b0, 1'(c == idly), 1'b0, 1'b0, 1'b0, 2'b00));
      if (c == idly) break;
    end
    if (idly >= int'(TIMEOUT)) begin
      exp_cause = 2'b10;
      trapped   = 1'b1;
      return;
    end
    rand_side();
    cyc("decode", exp_vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    if (!is_legal(op)) begin
      exp_cause = 2'b01;
      trapped   = 1'b1;
      return;
    end
    rand_side();
    cyc("execute", exp_vec(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int c = 0; c < int'(TIMEOUT); c++) begin
        rand_side();
        dmem_ack = 1'(c == ddly);
        cyc("mem", exp_vec(3'd4, 1'b0, 1'b1, ctl_mem_w, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        if (c == ddly) break;
      end
      if (ddly >= int'(TIMEOUT)) begin
        exp_cause = 2'b11;
        trapped   = 1'b1;
        return;
      end
    end
    rand_side();
    cyc("wb", exp_vec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, ctl_reg_wen, 1'b1, 1'b0, 2'b00));
    exp_cnt++;
  endtask

  task automatic trap_phase(input int n);
    for (int i = 0; i < n; i++) begin
      rand_side();
      opcode = 7'($urandom);
      cyc("trap", exp_vec(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_cause));
    end
  endtask

  task automatic run(input logic [6:0] op, input int idly, input int ddly);
    bit t;
    do_instr(op, idly, ddly, t);
    if (t) begin
      trap_phase(4);
      do_reset();
    end
  endtask

  initial begin
    bit         t;
    logic [6:0] op;
    int         idly;
    int         ddly;
    rst = 1'b1; opcode = OP_ALU; ctl_reg_wen = 1'b0; ctl_mem_w = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    do_reset();

    for (int i = 0; i < 3; i++) run(OP_ALU, 0, 0);
    check_eq("alu_cnt3", 32'(instr_cnt), 32'd3);
    run(OP_STORE, 0, 3);
    run(OP_LOAD, 0, 0);
    run(7'b1111111, 0, 0);
    check_eq("after_illegal_cnt", 32'(instr_cnt), 32'd0);

    // Timeout boundaries: ack on the last allowed cycle wins, one later traps
    run(OP_ALU, 14, 0);
    run(OP_ALU, 15, 0);
    run(OP_LOAD, 2, 14);
    run(OP_STORE, 0, 15);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = legal_ops[$urandom_range(0, 7)];
      idly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
      ddly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
      run(op, idly, ddly);
    end

    do_reset();
    for (int i = 0; i < 17; i++) run(OP_ALU, 0, 0);
    check_eq("cnt_wrap", 32'(instr_cnt), 32'd1);

    // Reset while a data request is outstanding
    do_instr(OP_ALU, 0, 0, t);
    opcode = OP_LOAD;
    rand_side(); imem_ack = 1'b1;
    cyc("f_mem", exp_vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    rand_side();
    cyc("d_mem", exp_vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    rand_side();
    cyc("e_mem", exp_vec(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    rand_side(); dmem_ack = 1'b0;
    cyc("m_mem", exp_vec(3'd4, 1'b0, 1'b1, ctl_mem_w, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    rst = 1'b1;
    rand_side(); dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    exp_cnt = 0;
    @(negedge clk);
    check_eq("rst_mem_dreq", 32'(dmem_req), 32'd0);
    check_eq("rst_mem_state", 32'(state), 32'd0);
    check_eq("rst_mem_cnt", 32'(instr_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
